// File: rtl/unified_buffer_stream_if.sv
// Bus interface for unified_buffer_stream.
// Groups the write port, the burst read port with valid/ready handshake,
// and the status/error signals.
//   master : the agent driving writes, burst requests, rd_ready and err_clr
//   slave  : the buffer itself
interface unified_buffer_stream_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 2,
  parameter int DEPTH  = 64,
  parameter int CW     = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [N_CH*DATA_W-1:0]   wr_data;
  logic [AW-1:0]            wr_ptr;
  logic                     rd_start;
  logic [AW-1:0]            rd_addr;
  logic [CW-1:0]            rd_count;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [N_CH*DATA_W-1:0]   rd_data;
  logic                     rd_last;
  logic                     busy;
  logic                     err;
  logic                     err_clr;

  modport master (
    output wr_en, wr_addr, wr_data, rd_start, rd_addr, rd_count, rd_ready, err_clr,
    input  wr_ptr, rd_valid, rd_data, rd_last, busy, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_start, rd_addr, rd_count, rd_ready, err_clr,
    output wr_ptr, rd_valid, rd_data, rd_last, busy, err
  );
endinterface

// File: rtl/unified_buffer_stream.sv
// Scratch memory of DEPTH words between the accumulator bank and the input
// setup buffer. Vectors of N_CH words are written through a registered write
// port and read back as bursts with valid/ready backpressure. All address
// arithmetic wraps modulo DEPTH.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (clears memory, outputs, FSM)
//   bus   : unified_buffer_stream_if.slave (write port, burst read port,
//           wr_ptr, busy, sticky err with err_clr)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no burst; rd_start with nonzero rd_count loads vector 0
// S_STREAM | rd_data holds a valid vector; advances on rd_ready
module unified_buffer_stream #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 2,
  parameter int DEPTH  = 64,
  parameter int CW     = 8
) (
  input logic                    clk,
  input logic                    reset,
  unified_buffer_stream_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = N_CH * DATA_W;
  localparam logic [AW-1:0] STEP = AW'(N_CH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     next_base;
  logic [CW-1:0]     remaining;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic [VW-1:0]     rd_data_q;
  logic              err_q;
  logic              start_ok;
  logic [AW-1:0]     fetch_base;
  logic [VW-1:0]     fetch_vec;

  assign start_ok   = (state == S_IDLE) && bus.rd_start && (bus.rd_count != '0);
  // In IDLE the fetch is for vector 0 of a new burst, otherwise for the next one.
  assign fetch_base = (state == S_IDLE) ? bus.rd_addr : next_base;

  // Memory is sampled pre-edge, so a write on the loading edge is not seen.
  always_comb begin
    fetch_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      fetch_vec[i*DATA_W +: DATA_W] = mem[fetch_base + AW'(i)];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      wr_ptr_q <= '0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < N_CH; i++) begin
        mem[bus.wr_addr + AW'(i)] <= bus.wr_data[i*DATA_W +: DATA_W];
      end
      wr_ptr_q <= bus.wr_addr + STEP;
    end
  end

  // remaining counts vectors of the burst not yet loaded into rd_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      next_base  <= '0;
      remaining  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state      <= S_STREAM;
            rd_valid_q <= 1'b1;
            rd_data_q  <= fetch_vec;
            rd_last_q  <= (bus.rd_count == CW'(1));
            next_base  <= bus.rd_addr + STEP;
            remaining  <= bus.rd_count - CW'(1);
          end
        end
        S_STREAM: begin
          if (bus.rd_ready) begin
            if (rd_last_q) begin
              state      <= S_IDLE;
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
            end else begin
              rd_data_q  <= fetch_vec;
              next_base  <= next_base + STEP;
              remaining  <= remaining - CW'(1);
              rd_last_q  <= (remaining == CW'(1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    err_q <= 1'b0;
    else if (bus.rd_start && (state == S_STREAM))  err_q <= 1'b1;
    else if (bus.err_clr)                          err_q <= 1'b0;
  end

  assign bus.wr_ptr   = wr_ptr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = (state == S_STREAM);
  assign bus.err      = err_q;
endmodule

// File: doc/unified_buffer_stream.md
Name: unified_buffer_stream

Overview:
- Parametrised successor to the unified buffer: on-chip scratch memory of DEPTH words of DATA_W bits, written as N_CH-word vectors from the accumulator bank and read back as a burst of N_CH-word vectors into the input setup buffer.
- Adds a registered write port, a burst read engine with valid/ready backpressure, modulo-DEPTH address wrap, and a sticky error flag. Sits between the accumulators and the input setup / systolic array.

Parameters:
- DATA_W, 8, bits per word.
- N_CH, 2, words per vector (accumulator channels / array width); 1 to 8.
- DEPTH, 64, number of words; power of two, at least N_CH.
- AW, $clog2(DEPTH), word-address width (derived, not overridable).
- CW, 8, burst-length counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe: store one vector this cycle.
- wr_addr  in  AW  base word address of the write vector.
- wr_data  in  N_CH*DATA_W  write vector; lane i occupies bits [i*DATA_W +: DATA_W].
- wr_ptr  out  AW  next free address: (last wr_addr + N_CH) mod DEPTH.
- rd_start  in  1  start-burst request.
- rd_addr  in  AW  base word address of the burst.
- rd_count  in  CW  number of vectors in the burst.
- rd_valid  out  1  rd_data holds a valid vector.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  N_CH*DATA_W  read vector, same lane packing as wr_data.
- rd_last  out  1  qualifies the final vector of the burst.
- busy  out  1  read engine is not IDLE.
- err  out  1  sticky: rd_start was received while busy.
- err_clr  in  1  clears err.

Behaviour:
- Reset (reset=0, asynchronous): all DEPTH words to 0; wr_ptr, rd_valid, rd_data, rd_last, busy and err to 0; FSM to IDLE. Asserting reset mid-burst aborts the burst immediately, with no further rd_valid.
- Addressing: lane i of any vector at base A maps to word (A+i) mod DEPTH. Burst vector k uses base (rd_addr + k*N_CH) mod DEPTH. Wrap is silent and is not an error.
- Write: on a clk edge with wr_en=1, all N_CH lanes are written and wr_ptr is updated. Writes are always accepted, in any FSM state, and take one cycle.
- FSM IDLE: on rd_start=1 with rd_count!=0, latch the base address and count, go to STREAM, and set busy=1 in the next cycle. rd_start with rd_count=0 is a no-op: stay IDLE, no rd_valid, no err.
- FSM STREAM: vector 0 is presented with rd_valid=1 in the cycle after rd_start (latency 1). A vector is transferred on any edge where rd_valid=1 and rd_ready=1. After a transfer the next vector is presented on the following cycle with no bubble. While rd_ready=0, rd_data, rd_valid and rd_last hold stable.
- rd_last=1 only together with the final vector. On transfer of that vector the FSM returns to IDLE: rd_valid, rd_last and busy are 0 in the next cycle.
- A new rd_start may be accepted in the cycle after busy falls, not in the transfer cycle of the last vector.
- Read/write interaction: a vector is sampled from memory on the edge that loads it into rd_data. A write on that same edge is not seen (old data); a write on any earlier edge is seen. Data already held during a stall is not updated by later writes.
- err: set on any edge where rd_start=1 and busy=1. The request is ignored and the current burst is unaffected. err_clr=1 clears it; if err_clr and a new error coincide, set wins.
- Width rules: rd_count is unsigned, so up to 2^CW-1 vectors. Address arithmetic is done in AW bits with natural wrap.

Test Plan:
- Reset/basic, defaults: write wr_addr=0 data {lane1=8'h22, lane0=8'h11}, then wr_addr=2 data {8'h44, 8'h33}; rd_start rd_addr=0 rd_count=2, rd_ready=1 -> rd_valid one cycle after start, vectors {22,11} then {44,33} on consecutive cycles, rd_last on the second, wr_ptr=4, busy falls after.
- Wrap: write wr_addr=63 data {8'hBB, 8'hAA} -> word 63=AA, word 0=BB, wr_ptr=1; burst rd_addr=63 rd_count=1 -> rd_data {BB,AA}, rd_last=1.
- Backpressure: 3-vector burst, rd_ready low for 4 cycles after the first vector -> rd_data and rd_valid held unchanged, then 3 transfers total, rd_last only on the third.
- Collision: write wr_addr=4 new data on the same edge vector 0 of a burst at rd_addr=4 is loaded -> old data returned. A repeat burst afterwards returns the new data.
- Error/no-op: rd_start during a burst -> err=1, burst length unchanged; err_clr -> err=0; rd_start with rd_count=0 -> no rd_valid, busy stays 0.
- Reset mid-burst: drop reset during vector 1 of 4 -> all outputs 0 asynchronously, memory reads back 0, FSM IDLE after release.
